// File: rtl/pll_lock_ctrl.sv
// Acquisition and lock sequencer for the charge-pump PLL: precharge, fast and slow acquisition,
// then locked operation, qualified by counting PFD activity over fixed windows.
module pll_lock_ctrl #(
    parameter int unsigned WIN         = 16,
    parameter int unsigned ERR_TOL     = 2,
    parameter int unsigned GOOD_WIN    = 4,
    parameter int unsigned MISS_MAX    = 2,
    parameter int unsigned PRECHG      = 32,
    parameter int unsigned ACQ_TIMEOUT = 64
) (
    input  logic       refclk,
    input  logic       rst,
    input  logic       enable,
    input  logic       up,
    input  logic       down,
    output logic       cp_en,
    output logic [1:0] cp_gain,
    output logic       precharge,
    output logic       locked,
    output logic       lock_lost,
    output logic [3:0] retry_cnt,
    output logic [2:0] state
);

    localparam int unsigned WW = $clog2(WIN);
    localparam int unsigned EW = $clog2(WIN + 1);
    localparam int unsigned GW = $clog2(GOOD_WIN + 1);
    localparam int unsigned MW = $clog2(MISS_MAX + 1);
    localparam int unsigned PW = $clog2(PRECHG + 1);
    localparam int unsigned TW = $clog2(ACQ_TIMEOUT + 1);

    localparam logic [WW-1:0] WinLast = WW'(WIN - 1);

    typedef enum logic [2:0] {
        StIdle      = 3'd0,
        StPrecharge = 3'd1,
        StFast      = 3'd2,
        StSlow      = 3'd3,
        StLocked    = 3'd4
    } st_e;

    st_e           st_q, st_d;
    logic [WW-1:0] win_q, win_d;
    logic [EW-1:0] err_q, err_d, err_tot;
    logic [GW-1:0] good_q, good_d, good_nx;
    logic [MW-1:0] miss_q, miss_d, miss_nx;
    logic [TW-1:0] tmo_q, tmo_d, tmo_nx;
    logic [PW-1:0] pre_q, pre_d;
    logic [3:0]    retry_q, retry_d;
    logic          lost_d, clr, eval, good_win;
    logic          cp_en_d, precharge_d, locked_d;
    logic [1:0]    cp_gain_d;

    always_comb begin
        st_d     = st_q;
        win_d    = win_q;
        err_d    = err_q;
        good_d   = good_q;
        miss_d   = miss_q;
        tmo_d    = tmo_q;
        pre_d    = pre_q;
        retry_d  = retry_q;
        lost_d   = 1'b0;
        clr      = 1'b0;
        // The evaluation edge's own PFD sample belongs to the window being judged.
        err_tot  = err_q + EW'(up | down);
        eval     = (win_q == WinLast);
        good_win = (32'(err_tot) <= ERR_TOL);
        good_nx  = good_win ? good_q + GW'(1) : '0;
        miss_nx  = good_win ? '0 : miss_q + MW'(1);
        tmo_nx   = tmo_q + TW'(1);

        if (!enable) begin
            st_d    = StIdle;
            clr     = 1'b1;
            retry_d = '0;
        end else begin
            unique case (st_q)
                StIdle: begin
                    st_d    = StPrecharge;
                    clr     = 1'b1;
                    retry_d = '0;
                end
                StPrecharge: begin
                    if (32'(pre_q) == PRECHG - 1) begin
                        st_d = StFast;
                        clr  = 1'b1;
                    end else begin
                        pre_d = pre_q + PW'(1);
                    end
                end
                StFast, StSlow: begin
                    if (eval) begin
                        // Advance wins over timeout when both land on the same window.
                        if (32'(good_nx) == GOOD_WIN) begin
                            st_d = (st_q == StFast) ? StSlow : StLocked;
                            clr  = 1'b1;
                        end else if (32'(tmo_nx) == ACQ_TIMEOUT) begin
                            st_d = StPrecharge;
                            clr  = 1'b1;
                            if (retry_q != 4'hf) begin
                                retry_d = retry_q + 4'd1;
                            end
                        end else begin
                            good_d = good_nx;
                            tmo_d  = tmo_nx;
                        end
                    end
                end
                StLocked: begin
                    if (eval) begin
                        if (32'(miss_nx) == MISS_MAX) begin
                            st_d   = StFast;
                            clr    = 1'b1;
                            lost_d = 1'b1;
                        end else begin
                            miss_d = miss_nx;
                        end
                    end
                end
                default: begin
                    st_d = StIdle;
                    clr  = 1'b1;
                end
            endcase
        end

        if (clr) begin
            win_d  = '0;
            err_d  = '0;
            good_d = '0;
            miss_d = '0;
            tmo_d  = '0;
            pre_d  = '0;
        end else if (st_q inside {StFast, StSlow, StLocked}) begin
            win_d = eval ? '0 : win_q + WW'(1);
            err_d = eval ? '0 : err_tot;
        end
    end

    // Outputs decode the next state so they line up with the state register.
    always_comb begin
        cp_en_d     = st_d inside {StFast, StSlow, StLocked};
        precharge_d = (st_d == StPrecharge);
        locked_d    = (st_d == StLocked);
        case (st_d)
            StFast:   cp_gain_d = 2'b11;
            StSlow:   cp_gain_d = 2'b10;
            StLocked: cp_gain_d = 2'b01;
            default:  cp_gain_d = 2'b00;
        endcase
    end

    always_ff @(posedge refclk or posedge rst) begin
        if (rst) begin
            st_q      <= StIdle;
            win_q     <= '0;
            err_q     <= '0;
            good_q    <= '0;
            miss_q    <= '0;
            tmo_q     <= '0;
            pre_q     <= '0;
            retry_q   <= '0;
            cp_en     <= 1'b0;
            cp_gain   <= 2'b00;
            precharge <= 1'b0;
            locked    <= 1'b0;
            lock_lost <= 1'b0;
        end else begin
            st_q      <= st_d;
            win_q     <= win_d;
            err_q     <= err_d;
            good_q    <= good_d;
            miss_q    <= miss_d;
            tmo_q     <= tmo_d;
            pre_q     <= pre_d;
            retry_q   <= retry_d;
            cp_en     <= cp_en_d;
            cp_gain   <= cp_gain_d;
            precharge <= precharge_d;
            locked    <= locked_d;
            lock_lost <= lost_d;
        end
    end

    assign state     = st_q;
    assign retry_cnt = retry_q;

endmodule

// File: tb/tb_pll_lock_ctrl.sv
// Bench for pll_lock_ctrl: directed acquisition/lock scenarios plus randomized PFD activity,
// checked every cycle against a window-arithmetic reference model.
module tb_pll_lock_ctrl;

    localparam int WIN         = 16;
    localparam int ERR_TOL     = 2;
    localparam int GOOD_WIN    = 4;
    localparam int MISS_MAX    = 2;
    localparam int PRECHG      = 32;
    localparam int ACQ_TIMEOUT = 64;

    logic       refclk = 1'b0;
    logic       rst, enable, up, down;
    logic       cp_en, precharge, locked, lock_lost;
    logic [1:0] cp_gain;
    logic [3:0] retry_cnt;
    logic [2:0] state;

    int total = 0;
    int bad   = 0;
    int lost_seen = 0;

    // Reference model: state number, edges spent in state, errors in current window, runs.
    int m_state, m_tis, m_errs, m_good_run, m_miss_run, m_evals, m_retry;
    int m_lost;

    always #5 refclk = ~refclk;

    pll_lock_ctrl #(
        .WIN         (WIN),
        .ERR_TOL     (ERR_TOL),
        .GOOD_WIN    (GOOD_WIN),
        .MISS_MAX    (MISS_MAX),
        .PRECHG      (PRECHG),
        .ACQ_TIMEOUT (ACQ_TIMEOUT)
    ) dut (
        .refclk    (refclk),
        .rst       (rst),
        .enable    (enable),
        .up        (up),
        .down      (down),
        .cp_en     (cp_en),
        .cp_gain   (cp_gain),
        .precharge (precharge),
        .locked    (locked),
        .lock_lost (lock_lost),
        .retry_cnt (retry_cnt),
        .state     (state)
    );

    task automatic check(input string tag, input int got, input int exp);
        total++;
        if (got != exp) begin
            bad++;
            $display("FAIL %s at %0t: got=%0d exp=%0d", tag, $time, got, exp);
        end
    endtask

    task automatic model_go(input int s);
        m_state    = s;
        m_tis      = 0;
        m_errs     = 0;
        m_good_run = 0;
        m_miss_run = 0;
        m_evals    = 0;
    endtask

    task automatic model_reset();
        model_go(0);
        m_retry = 0;
        m_lost  = 0;
    endtask

    task automatic model_step();
        int good;
        m_lost = 0;
        if (!enable) begin
            model_go(0);
            m_retry = 0;
        end else if (m_state == 0) begin
            model_go(1);
        end else if (m_state == 1) begin
            m_tis++;
            if (m_tis == PRECHG) model_go(2);
        end else begin
            m_tis++;
            m_errs += (up || down) ? 1 : 0;
            if (m_tis % WIN == 0) begin
                good   = (m_errs <= ERR_TOL) ? 1 : 0;
                m_errs = 0;
                m_evals++;
                if (m_state == 4) begin
                    m_miss_run = good ? 0 : m_miss_run + 1;
                    if (m_miss_run == MISS_MAX) begin
                        model_go(2);
                        m_lost = 1;
                    end
                end else begin
                    m_good_run = good ? m_good_run + 1 : 0;
                    if (m_good_run == GOOD_WIN) begin
                        model_go(m_state + 1);
                    end else if (m_evals == ACQ_TIMEOUT) begin
                        model_go(1);
                        if (m_retry < 15) m_retry++;
                    end
                end
            end
        end
    endtask

    task automatic compare_all();
        int g;
        case (m_state)
            2:       g = 3;
            3:       g = 2;
            4:       g = 1;
            default: g = 0;
        endcase
        check("state", int'(state), m_state);
        check("cp_en", int'(cp_en), (m_state >= 2) ? 1 : 0);
        check("cp_gain", int'(cp_gain), g);
        check("precharge", int'(precharge), (m_state == 1) ? 1 : 0);
        check("locked", int'(locked), (m_state == 4) ? 1 : 0);
        check("lock_lost", int'(lock_lost), m_lost);
        check("retry_cnt", int'(retry_cnt), m_retry);
    endtask

    task automatic tick();
        @(posedge refclk);
        if (rst) model_reset();
        else model_step();
        #1;
        compare_all();
        if (lock_lost) lost_seen++;
    endtask

    task automatic run_until(input int target, input int budget, input string tag);
        int n = 0;
        while (m_state != target && n < budget) begin
            tick();
            n++;
        end
        check(tag, int'(state), target);
    endtask

    task automatic align_window();
        int n = 0;
        while ((m_tis % WIN) != 0 && n < 2 * WIN) begin
            tick();
            n++;
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int p1, p2, k;
        rst    = 1'b1;
        enable = 1'b1;
        up     = 1'b0;
        down   = 1'b0;
        model_reset();
        repeat (3) tick();
        #2 rst = 1'b0;

        // Clean acquisition with the documented edge numbers.
        for (int e = 1; e <= 170; e++) begin
            tick();
            if (e == 1) check("edge1_state", int'(state), 1);
            if (e == 33) begin
                check("edge33_state", int'(state), 2);
                check("edge33_gain", int'(cp_gain), 3);
            end
            if (e == 97) begin
                check("edge97_state", int'(state), 3);
                check("edge97_gain", int'(cp_gain), 2);
            end
            if (e == 161) begin
                check("edge161_locked", int'(locked), 1);
                check("edge161_gain", int'(cp_gain), 1);
            end
        end

        // One bad window followed by a good one keeps lock.
        align_window();
        for (int c = 0; c < 2 * WIN; c++) begin
            down = (c < 3);
            tick();
        end
        check("one_miss_locked", int'(locked), 1);

        // Two consecutive bad windows drop lock with a single pulse.
        lost_seen = 0;
        for (int c = 0; c < 2 * WIN; c++) begin
            down = ((c % WIN) < 4);
            tick();
        end
        down = 1'b0;
        check("lost_state", int'(state), 2);
        check("lost_locked", int'(locked), 0);
        check("lost_gain", int'(cp_gain), 3);
        check("lost_pulses", lost_seen, 1);

        // Two error cycles per window is still good: FAST advances after 64 edges.
        for (int w = 0; w < 4; w++) begin
            p1 = $urandom_range(0, WIN - 1);
            p2 = (p1 + $urandom_range(1, WIN - 1)) % WIN;
            for (int c = 0; c < WIN; c++) begin
                up = (c == p1 || c == p2);
                tick();
            end
        end
        up = 1'b0;
        check("two_err_adv", int'(state), 3);

        // Three error cycles (one with up&down) break the run; advance slips one window.
        for (int c = 0; c < 5 * WIN; c++) begin
            up   = (c == 0 || c == 5);
            down = (c == 0 || c == 9);
            tick();
            if (c == 4 * WIN - 1) check("slip_still_slow", int'(state), 3);
        end
        up   = 1'b0;
        down = 1'b0;
        check("slip_locked", int'(state), 4);

        // Randomized PFD activity with occasional enable drops.
        for (int blk = 0; blk < 30; blk++) begin
            k = $urandom_range(0, 4);
            for (int c = 0; c < 200; c++) begin
                up     = ($urandom_range(0, 15) < k);
                down   = ($urandom_range(0, 31) < k);
                enable = ($urandom_range(0, 1999) != 0);
                tick();
            end
        end
        enable = 1'b1;
        up     = 1'b0;
        down   = 1'b0;

        // Persistent up forces timeouts; retry count saturates at 15.
        enable = 1'b0;
        tick();
        enable = 1'b1;
        for (int r = 1; r <= 17; r++) begin
            run_until(2, 200, "retry_reach_fast");
            up = 1'b1;
            repeat (WIN * ACQ_TIMEOUT) tick();
            if (r == 1) begin
                check("retry1_state", int'(state), 1);
                check("retry1_cnt", int'(retry_cnt), 1);
            end
        end
        check("retry_sat", int'(retry_cnt), 15);
        up = 1'b0;

        // Enable drop in LOCKED: straight to IDLE, retries cleared, no loss pulse.
        run_until(4, 400, "relock");
        enable = 1'b0;
        tick();
        check("en_drop_state", int'(state), 0);
        check("en_drop_retry", int'(retry_cnt), 0);
        check("en_drop_lost", int'(lock_lost), 0);
        enable = 1'b1;

        // Asynchronous reset between edges while in SLOW.
        run_until(3, 200, "reach_slow");
        #2 rst = 1'b1;
        #1;
        model_reset();
        compare_all();
        check("async_rst_gain", int'(cp_gain), 0);
        tick();
        #2 rst = 1'b0;
        tick();
        check("post_rst_state", int'(state), 1);
        repeat (5) tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
